comparator_bist: RTL and testbench
==================================

# comparator_bist

Self-test driver and checker for the `fourbit_comparator` datapath on the Spartan-3 clock board. On a `start` pulse it sweeps every (a, b) operand pair into the comparator and samples `eg`/`agb`/`alb` after a programmable settle time. It checks each sample against a golden model and reports pass/fail, an error count and the first failing vector. It sits between the board-level control logic and the comparator instance, replacing bench stimulus in hardware.

## Interface
- `WIDTH`, 4: operand width; sweep covers 2^(2·WIDTH) vectors.
- `SETTLE`, 1: cycles between driving a vector and sampling results; legal range ≥1.

- `clk` in 1: sole clock; all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle request; accepted only in IDLE or DONE.
- `a_o` out WIDTH: operand a to comparator.
- `b_o` out WIDTH: operand b to comparator.
- `eg_i` in 1: comparator equal result.
- `agb_i` in 1: comparator a>b result.
- `alb_i` in 1: comparator a<b result.
- `busy` out 1: high in SETTLE and CHECK.
- `done` out 1: high in DONE; held until next accepted `start` or reset.
- `pass` out 1: `done` && `err_count`==0.
- `err_count` out 2·WIDTH+1: mismatching vectors in the last/current run.
- `fail_a` out WIDTH: a of first mismatch; 0 if none.
- `fail_b` out WIDTH: b of first mismatch; 0 if none.

## Operation
- Vector index `idx` (2·WIDTH bits, registered): `a_o`=idx[2W-1:W], `b_o`=idx[W-1:0]. a is the outer loop, b the inner loop.
- Golden model: eg=(a==b), agb=(a>b), alb=(a<b), all unsigned. A vector mismatches if any of the three bits differs, including multiple-high or all-low patterns.
- States:
  - IDLE: on `start`, clear idx, `wait_cnt`, `err_count`, `fail_a`, `fail_b` and the first-fail flag, then go to SETTLE.
  - SETTLE: if `wait_cnt`==SETTLE-1, go to CHECK; else increment `wait_cnt`.
  - CHECK: compare inputs against the model. On mismatch, increment `err_count`; if it is the first mismatch, capture `fail_a`/`fail_b`. If idx is all-ones, go to DONE; else increment idx, clear `wait_cnt`, go to SETTLE.
  - DONE: on `start`, behave as IDLE's start transition.
- `start` while `busy` is ignored; it does not restart or queue.
- `err_count` cannot overflow (max 2^(2W)), so no saturation logic is needed.
- Reset, including mid-run: immediately go to IDLE. All outputs go to 0 (`a_o`, `b_o`, `busy`, `done`, `pass`, `err_count`, `fail_a`, `fail_b`). No partial result is retained.

## Timing
- `start` sampled high at edge T: `busy`=1 and `a_o`/`b_o`=0/0 from T+1.
- Each vector occupies SETTLE+1 cycles. Results are sampled in the CHECK cycle, SETTLE cycles after the operands changed.
- Total run time is 2^(2W)·(SETTLE+1) cycles from T+1. For defaults, that is 512 cycles; `done` rises at T+513.
- `err_count`, `fail_a` and `fail_b` update the edge after the CHECK cycle.
- `a_o`/`b_o` are registered with no combinational path from inputs. They hold the last vector (all-ones/all-ones) in DONE and return to 0 only on reset.

## Structure
- Shared package: state encoding constants (IDLE, SETTLE, CHECK, DONE) and a function or constant for the mismatch-vector width 2·WIDTH+1.
- One natural sub-module: `cmp_golden` (combinational WIDTH-bit golden eg/agb/alb model). It is reused by the checker and by the bench scoreboard.
- FSM, index counter, settle counter and result registers live in the top module.

## Test plan
- Correct comparator, defaults: pulse `start` → `busy` for 512 cycles, then `done`=1, `pass`=1, `err_count`=0, `fail_a`/`fail_b`=0/0.
- Fault model `eg` stuck-at-0 → `done` with `err_count`=16, `fail_a`=0, `fail_b`=0, `pass`=0.
- Fault model `agb`/`alb` swapped → `err_count`=240, first fail `fail_a`=0, `fail_b`=1.
- `start` re-pulsed at cycle 50 of a run → ignored; `done` still rises at T+513 with an unchanged sweep.
- Async `rst` asserted mid-cycle during vector idx=100 → all outputs 0 and IDLE without waiting for an edge. A following `start` completes a clean 512-cycle run.
- `SETTLE`=3 with a comparator model delayed 2 cycles → run takes 1024 cycles and `pass`=1. With `SETTLE`=1 and the same model → `pass`=0 and `err_count`>0.

Source files
------------

// File: rtl/comparator_bist_pkg.sv
// ============================================================================
// Module      : comparator_bist_pkg
// Description : Shared state encoding and sizing helpers for comparator_bist.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package comparator_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Mismatch counter must hold 2^(2W), one more than the largest index.
    function automatic int err_width(input int width);
        return 2 * width + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/comparator_bist_cmp_golden.sv
// ============================================================================
// Module      : cmp_golden
// Description : Combinational unsigned golden model producing eg/agb/alb.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmp_golden #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_eg,
    output logic             o_agb,
    output logic             o_alb
);

    assign o_eg  = (i_a == i_b);
    assign o_agb = (i_a >  i_b);
    assign o_alb = (i_a <  i_b);

endmodule

`default_nettype wire

// File: rtl/comparator_bist.sv
// ============================================================================
// Module      : comparator_bist
// Description : Exhaustive sweep driver and checker for a WIDTH-bit comparator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module comparator_bist
    import comparator_bist_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic [WIDTH-1:0]           a_o,
    output logic [WIDTH-1:0]           b_o,
    input  logic                       eg_i,
    input  logic                       agb_i,
    input  logic                       alb_i,
    output logic                       busy,
    output logic                       done,
    output logic                       pass,
    output logic [2*WIDTH:0]           err_count,
    output logic [WIDTH-1:0]           fail_a,
    output logic [WIDTH-1:0]           fail_b
);

    localparam int c_IDXW = 2 * WIDTH;
    localparam int c_ERRW = err_width(WIDTH);
    localparam int c_WCW  = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [c_WCW-1:0] c_SETTLE_LAST = c_WCW'(SETTLE - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_IDXW-1:0]   r_idx;
    logic [c_WCW-1:0]    r_wait;
    logic [c_ERRW-1:0]   r_err;
    logic [WIDTH-1:0]    r_fail_a;
    logic [WIDTH-1:0]    r_fail_b;
    logic                r_first_seen;

    logic                w_eg;
    logic                w_agb;
    logic                w_alb;
    logic                w_mismatch;
    logic                w_settle_last;
    logic                w_idx_last;
    logic                w_accept;

    cmp_golden #(
        .WIDTH (WIDTH)
    ) u_golden (
        .i_a   (r_idx[c_IDXW-1:WIDTH]),
        .i_b   (r_idx[WIDTH-1:0]),
        .o_eg  (w_eg),
        .o_agb (w_agb),
        .o_alb (w_alb)
    );

    // Any disagreement counts, including multi-high and all-low patterns.
    assign w_mismatch    = ({eg_i, agb_i, alb_i} != {w_eg, w_agb, w_alb});
    assign w_settle_last = (r_wait == c_SETTLE_LAST);
    assign w_idx_last    = (r_idx == {c_IDXW{1'b1}});
    assign w_accept      = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (w_settle_last) begin
                    w_state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                w_state_nxt = w_idx_last ? ST_DONE : ST_SETTLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx        <= '0;
            r_wait       <= '0;
            r_err        <= '0;
            r_fail_a     <= '0;
            r_fail_b     <= '0;
            r_first_seen <= 1'b0;
        end else if (w_accept) begin
            r_idx        <= '0;
            r_wait       <= '0;
            r_err        <= '0;
            r_fail_a     <= '0;
            r_fail_b     <= '0;
            r_first_seen <= 1'b0;
        end else if (r_state == ST_SETTLE) begin
            if (!w_settle_last) begin
                r_wait <= r_wait + 1'b1;
            end
        end else if (r_state == ST_CHECK) begin
            if (w_mismatch) begin
                r_err <= r_err + 1'b1;
                if (!r_first_seen) begin
                    r_first_seen <= 1'b1;
                    r_fail_a     <= r_idx[c_IDXW-1:WIDTH];
                    r_fail_b     <= r_idx[WIDTH-1:0];
                end
            end
            // Operands freeze on the final vector so DONE shows all-ones.
            if (!w_idx_last) begin
                r_idx  <= r_idx + 1'b1;
                r_wait <= '0;
            end
        end
    end

    assign a_o       = r_idx[c_IDXW-1:WIDTH];
    assign b_o       = r_idx[WIDTH-1:0];
    assign busy      = (r_state == ST_SETTLE) || (r_state == ST_CHECK);
    assign done      = (r_state == ST_DONE);
    assign pass      = done && (r_err == '0);
    assign err_count = r_err;
    assign fail_a    = r_fail_a;
    assign fail_b    = r_fail_b;

endmodule

`default_nettype wire

// File: tb/tb_comparator_bist.sv
// ============================================================================
// Module      : tb_comparator_bist
// Description : Directed self-checking bench with fault-injected comparator models.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_comparator_bist;

    logic       clk;
    logic       rst;
    logic       start0;
    logic       start1;
    int         fault_mode;
    int         n_checks;
    int         n_fail;

    logic [3:0] a0, b0, a1, b1;
    logic       eg0, agb0, alb0;
    logic       eg1, agb1, alb1;
    logic       busy0, done0, pass0, busy1, done1, pass1;
    logic [8:0] err0, err1;
    logic [3:0] fa0, fb0, fa1, fb1;

    logic       g0_eg, g0_agb, g0_alb, g1_eg, g1_agb, g1_alb;
    logic [2:0] d0_1, d0_2, d1_1, d1_2;

    comparator_bist #(.WIDTH(4), .SETTLE(1)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .a_o(a0), .b_o(b0),
        .eg_i(eg0), .agb_i(agb0), .alb_i(alb0), .busy(busy0), .done(done0),
        .pass(pass0), .err_count(err0), .fail_a(fa0), .fail_b(fb0)
    );

    comparator_bist #(.WIDTH(4), .SETTLE(3)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .a_o(a1), .b_o(b1),
        .eg_i(eg1), .agb_i(agb1), .alb_i(alb1), .busy(busy1), .done(done1),
        .pass(pass1), .err_count(err1), .fail_a(fa1), .fail_b(fb1)
    );

    cmp_golden #(.WIDTH(4)) u_ref0 (.i_a(a0), .i_b(b0), .o_eg(g0_eg), .o_agb(g0_agb), .o_alb(g0_alb));
    cmp_golden #(.WIDTH(4)) u_ref1 (.i_a(a1), .i_b(b1), .o_eg(g1_eg), .o_agb(g1_agb), .o_alb(g1_alb));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two-cycle delayed comparator models
    always @(posedge clk) begin
        d0_1 <= {g0_eg, g0_agb, g0_alb};
        d0_2 <= d0_1;
        d1_1 <= {g1_eg, g1_agb, g1_alb};
        d1_2 <= d1_1;
    end

    always_comb begin
        {eg0, agb0, alb0} = {g0_eg, g0_agb, g0_alb};
        case (fault_mode)
            1:       {eg0, agb0, alb0} = {1'b0, g0_agb, g0_alb};
            2:       {eg0, agb0, alb0} = {g0_eg, g0_alb, g0_agb};
            3:       {eg0, agb0, alb0} = d0_2;
            default: {eg0, agb0, alb0} = {g0_eg, g0_agb, g0_alb};
        endcase
        {eg1, agb1, alb1} = d1_2;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Start DUT0 (and optionally DUT1), check T+1 state, then DUT0 done timing.
    task automatic do_run(input string tag, input bit both, input bit repulse);
        @(negedge clk);
        start0 = 1'b1;
        start1 = both;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
        chk({tag, "_busy_t1"}, 32'(busy0), 32'd1);
        chk({tag, "_ab_t1"}, {24'd0, a0, b0}, 32'd0);
        for (int k = 1; k < 512; k++) begin
            @(posedge clk);
            #1;
            if (repulse && k == 49) start0 = 1'b1;
            if (repulse && k == 50) start0 = 1'b0;
        end
        chk({tag, "_done_early"}, 32'(done0), 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_done"}, 32'(done0), 32'd1);
        chk({tag, "_busy_end"}, 32'(busy0), 32'd0);
    endtask

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        fault_mode = 0;
        start0     = 1'b0;
        start1     = 1'b0;
        rst        = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ab", {24'd0, a0, b0}, 32'd0);
        chk("rst_flags", {29'd0, busy0, done0, pass0}, 32'd0);
        chk("rst_err", 32'(err0), 32'd0);
        chk("rst_fail", {24'd0, fa0, fb0}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Clean run with a start re-pulse mid-sweep
        do_run("clean", 1'b0, 1'b1);
        chk("clean_pass", 32'(pass0), 32'd1);
        chk("clean_err", 32'(err0), 32'd0);
        chk("clean_fail", {24'd0, fa0, fb0}, 32'd0);
        chk("clean_ab_hold", {24'd0, a0, b0}, 32'hFF);

        // eg stuck-at-0
        fault_mode = 1;
        do_run("egsa0", 1'b0, 1'b0);
        chk("egsa0_err", 32'(err0), 32'd16);
        chk("egsa0_fail", {24'd0, fa0, fb0}, 32'h00);
        chk("egsa0_pass", 32'(pass0), 32'd0);

        // agb/alb swapped
        fault_mode = 2;
        do_run("swap", 1'b0, 1'b0);
        chk("swap_err", 32'(err0), 32'd240);
        chk("swap_fail", {24'd0, fa0, fb0}, 32'h01);
        chk("swap_pass", 32'(pass0), 32'd0);

        // Delayed model: SETTLE=1 fails, SETTLE=3 passes in 1024 cycles
        fault_mode = 3;
        do_run("dly", 1'b1, 1'b0);
        chk("dly_s1_pass", 32'(pass0), 32'd0);
        chk("dly_s1_errnz", 32'(err0 != 9'd0), 32'd1);
        for (int k = 0; k < 511; k++) @(posedge clk);
        #1;
        chk("dly_s3_done_early", 32'(done1), 32'd0);
        @(posedge clk);
        #1;
        chk("dly_s3_done", 32'(done1), 32'd1);
        chk("dly_s3_pass", 32'(pass1), 32'd1);
        chk("dly_s3_err", 32'(err1), 32'd0);

        // Async reset mid-cycle while vector idx=100 is on the operands
        fault_mode = 1;
        @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        begin
            bit found;
            found = 1'b0;
            for (int k = 0; k < 600 && !found; k++) begin
                @(negedge clk);
                if (a0 == 4'd6 && b0 == 4'd4) found = 1'b1;
            end
            chk("idx100_found", 32'(found), 32'd1);
        end
        chk("pre_rst_err", 32'(err0), 32'd6);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_ab", {24'd0, a0, b0}, 32'd0);
        chk("arst_flags", {29'd0, busy0, done0, pass0}, 32'd0);
        chk("arst_err", 32'(err0), 32'd0);
        chk("arst_fail", {24'd0, fa0, fb0}, 32'd0);
        #1;
        rst = 1'b0;
        fault_mode = 0;
        do_run("post_rst", 1'b0, 1'b0);
        chk("post_rst_pass", 32'(pass0), 32'd1);
        chk("post_rst_err", 32'(err0), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
